// File: rtl/ram_fill_engine.sv
// RAM clear/fill sequencer: writes one constant word per clock over an inclusive
// address range, holding the CPU off the RAM port while it runs.
module ram_fill_engine #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int REQ_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [REQ_WIDTH-1:0]  range_lo,
  input  logic [REQ_WIDTH-1:0]  range_hi,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err_oob,
  output logic [REQ_WIDTH:0]    words_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [REQ_WIDTH-1:0] DEPTH_R    = REQ_WIDTH'(RAM_DEPTH);
  localparam logic [REQ_WIDTH-1:0] LAST_VALID = REQ_WIDTH'(RAM_DEPTH - 1);

  // Clamp the requested upper bound to the last real RAM word.
  function automatic logic [REQ_WIDTH-1:0] clamp_hi(input logic [REQ_WIDTH-1:0] hi);
    return (hi >= DEPTH_R) ? LAST_VALID : hi;
  endfunction

  state_t                  state, state_nx;
  logic [REQ_WIDTH-1:0]    cnt, cnt_nx, cnt_inc;
  logic [REQ_WIDTH-1:0]    last, last_nx;
  logic [DATA_WIDTH-1:0]   data_q, data_nx;
  logic                    we_nx, busy_nx, done_nx, err_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   wdata_nx;
  logic [REQ_WIDTH:0]      words_nx;

  assign cnt_inc  = cnt + REQ_WIDTH'(1);
  assign cpu_hold = busy;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    data_nx  = data_q;
    we_nx    = 1'b0;
    addr_nx  = '0;
    wdata_nx = '0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = err_oob;
    words_nx = words_written;

    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = range_lo;
          last_nx  = clamp_hi(range_hi);
          data_nx  = fill_data;
          words_nx = '0;
          err_nx   = (range_hi >= DEPTH_R) || (range_lo >= DEPTH_R);
          busy_nx  = 1'b1;
          // Empty or wholly out-of-range jobs skip straight to completion.
          if ((range_lo > range_hi) || (range_lo >= DEPTH_R)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = WRITE;
            we_nx    = 1'b1;
            addr_nx  = range_lo[ADDR_WIDTH-1:0];
            wdata_nx = fill_data;
          end
        end
      end

      WRITE: begin
        busy_nx  = 1'b1;
        words_nx = words_written + (REQ_WIDTH+1)'(1);
        // last never exceeds RAM_DEPTH-1, so the counter cannot wrap past it.
        if (cnt == last) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx   = cnt_inc;
          we_nx    = 1'b1;
          addr_nx  = cnt_inc[ADDR_WIDTH-1:0];
          wdata_nx = data_q;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= '0;
      data_q        <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_oob       <= 1'b0;
      words_written <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      last          <= last_nx;
      data_q        <= data_nx;
      ram_we        <= we_nx;
      ram_addr      <= addr_nx;
      ram_wdata     <= wdata_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      err_oob       <= err_nx;
      words_written <= words_nx;
    end
  end

endmodule
